chip8_keypad: RTL and testbench
===============================

Name: chip8_keypad

Overview:
- PS/2 front end for the Chip-8 machine. Takes the keyboard clock/data lines from hps_io and decodes set-2 scancodes.
- Outputs the 16-key hex keypad state, plus a one-shot key-press event for the Fx0A "wait for key" instruction.
- Sits between hps_io and chip8, in the clk_sys domain. Replaces raw ps2_clk/ps2_dat into the machine.

Parameters:
- TIMEOUT_CYCLES, 50000: clk_sys cycles without a PS/2 falling edge mid-frame before the receiver aborts (1 ms at 50 MHz).
- SYNC_STAGES, 2: synchroniser depth on ps2_clk/ps2_dat; minimum 2.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  PS/2 clock from hps_io (asynchronous, idle high).
- ps2_dat  in  1  PS/2 data from hps_io (asynchronous, idle high).
- clear  in  1  synchronous: drop all held keys and prefix flags (driven on core reset / ROM download).
- key_state  out  16  bit k = hex key k currently held.
- key_event  out  1  one-cycle pulse on a new key press.
- key_code  out  4  hex key of the last press; valid while key_event=1, held afterwards.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset: key_state=0, key_event=0, key_code=0, frame_err=0, receiver IDLE, prefix flags clear.
- ps2_clk/ps2_dat pass through SYNC_STAGES flops. A falling edge on synced clk is a sample point; data is sampled from the synced dat on that same cycle.
- Receiver FSM:
  - IDLE: sample 0 -> DATA with bitcnt=0; sample 1 -> stay IDLE (glitch, no error).
  - DATA: shift in LSB first; after 8 samples -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: sample 1 -> byte strobe (1 cycle), then IDLE; sample 0 -> frame_err pulse, discard, IDLE.
- Watchdog counter resets on every sample point and runs only outside IDLE. When it reaches TIMEOUT_CYCLES-1: frame_err pulse, IDLE, partial byte discarded.
- Decoder acts on the byte strobe; outputs are registered exactly 1 cycle after the strobe.
  - 0xF0: set brk.
  - 0xE0: set ext.
  - Any other byte with ext=1: ignored, both flags cleared.
  - Mapped byte, brk=1: clear key_state[k]; no event; flags cleared.
  - Mapped byte, brk=0: set key_state[k]. Pulse key_event and load key_code=k only if the bit was previously 0, so typematic repeats give no event. Flags cleared.
  - Unmapped byte (incl. 0xAA, 0xFA): no state change, flags cleared.
- Key map (key:scancode):
  - 1:16, 2:1E, 3:26, C:25
  - 4:15, 5:1D, 6:24, D:2D
  - 7:1C, 8:1B, 9:23, E:2B
  - A:1A, 0:22, B:21, F:2A
- clear: zeroes key_state, brk and ext next cycle and suppresses key_event. The receiver FSM is unaffected. If clear and a strobe coincide, clear wins and the byte is dropped.
- Multiple keys may be held simultaneously. Release of a key that is not held is a no-op.
- reset_n asserted mid-frame: immediate return to reset state; the partial frame is lost silently (no frame_err).

Optional Feature:
- Macro KEYPAD_PARITY_CHECK_EN.
- Defined: odd parity is checked across data+parity. A mismatch at STOP (stop bit otherwise good) gives a frame_err pulse and no byte strobe.
- Undefined: the parity bit is sampled and ignored; the PARITY state still exists so frame timing is identical.

Decomposition:
- Package chip8_kbd_pkg:
  - rx state enum (IDLE, DATA, PARITY, STOP).
  - scancode constants SC_BREAK=8'hF0, SC_EXT=8'hE0.
  - 16-entry scancode-to-key lookup function.
- One sub-module, ps2_rx_frame: synchroniser, edge detect, receiver FSM, watchdog. Outputs byte[7:0], byte_strobe, frame_err.
- The decoder and keypad register live in chip8_keypad.

Test Plan:
- Frames 1D, then F0 1D -> key_state[5] rises with one key_event pulse (key_code=5) 1 cycle after the strobe; bit 5 clears after the F0 1D strobe, no event.
- Make 22 sent 3 times (typematic) -> key_state[0]=1, exactly one key_event, key_code=0.
- E0 1D, then 2A -> no change from E0 1D; 2A sets bit 15 with event key_code=F (ext flag does not leak).
- Start+4 data bits, then idle TIMEOUT_CYCLES -> one frame_err pulse; the next full frame 16 sets key_state[1].
- Frame 16 with stop bit 0 -> frame_err, key_state unchanged. Frame 16 with wrong parity -> frame_err only with KEYPAD_PARITY_CHECK_EN, otherwise key_state[1]=1.
- Hold keys 1 and C, pulse clear on the same cycle as the strobe of make 15 -> key_state=0, no key_event; reset_n low mid-frame -> all outputs 0, no frame_err.

Source files
------------

// File: rtl/chip8_kbd_pkg.sv
// Shared types for the Chip-8 PS/2 keypad: receiver states, scancode constants
// and the set-2 scancode to hex-key lookup.
package chip8_kbd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef struct packed {
      logic       valid;
      logic [3:0] key;
   } key_lookup_t;

   // Layout mirrors the COSMAC VIP pad on the left block of a QWERTY keyboard.
   function automatic key_lookup_t sc_to_key(input logic [7:0] sc);
      key_lookup_t r;
      r.valid = 1'b1;
      r.key   = '0;
      case (sc)
         8'h16:   r.key = 4'h1;
         8'h1E:   r.key = 4'h2;
         8'h26:   r.key = 4'h3;
         8'h25:   r.key = 4'hC;
         8'h15:   r.key = 4'h4;
         8'h1D:   r.key = 4'h5;
         8'h24:   r.key = 4'h6;
         8'h2D:   r.key = 4'hD;
         8'h1C:   r.key = 4'h7;
         8'h1B:   r.key = 4'h8;
         8'h23:   r.key = 4'h9;
         8'h2B:   r.key = 4'hE;
         8'h1A:   r.key = 4'hA;
         8'h22:   r.key = 4'h0;
         8'h21:   r.key = 4'hB;
         8'h2A:   r.key = 4'hF;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, 11-bit frame FSM and
// mid-frame watchdog. Odd parity is enforced only with KEYPAD_PARITY_CHECK_EN.
module ps2_rx_frame
   import chip8_kbd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] rx_byte,
   output logic       byte_strobe,
   output logic       frame_err
);

   localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [STAGES-1:0] clk_sync_q;
   logic [STAGES-1:0] dat_sync_q;
   logic              clk_prev_q;
   logic              clk_s;
   logic              dat_s;
   logic              fall;

   rx_state_e         state_q;
   logic [2:0]        bitcnt_q;
   logic [7:0]        shift_q;
   logic [WD_W-1:0]   wdog_q;
   logic [7:0]        byte_q;
   logic              strobe_q;
   logic              err_q;
`ifdef KEYPAD_PARITY_CHECK_EN
   logic              parity_q;
`endif

   assign clk_s = clk_sync_q[STAGES-1];
   assign dat_s = dat_sync_q[STAGES-1];
   assign fall  = clk_prev_q & ~clk_s;

   // Lines idle high, so the synchroniser resets high to avoid a false edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[STAGES-2:0], ps2_clk};
         dat_sync_q <= {dat_sync_q[STAGES-2:0], ps2_dat};
         clk_prev_q <= clk_s;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         wdog_q   <= '0;
         byte_q   <= '0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
`ifdef KEYPAD_PARITY_CHECK_EN
         parity_q <= 1'b0;
`endif
      end else begin
         strobe_q <= 1'b0;
         err_q    <= 1'b0;

         if (state_q == IDLE || fall) begin
            wdog_q <= '0;
         end else begin
            wdog_q <= wdog_q + 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (fall && !dat_s) begin
                  state_q  <= DATA;
                  bitcnt_q <= '0;
               end
            end
            DATA: begin
               if (fall) begin
                  shift_q  <= {dat_s, shift_q[7:1]};
                  bitcnt_q <= bitcnt_q + 1'b1;
                  if (bitcnt_q == 3'd7) begin
                     state_q <= PARITY;
                  end
               end
            end
            PARITY: begin
               if (fall) begin
`ifdef KEYPAD_PARITY_CHECK_EN
                  parity_q <= dat_s;
`endif
                  state_q  <= STOP;
               end
            end
            STOP: begin
               if (fall) begin
                  state_q <= IDLE;
                  if (dat_s) begin
`ifdef KEYPAD_PARITY_CHECK_EN
                     if (^{shift_q, parity_q}) begin
                        strobe_q <= 1'b1;
                        byte_q   <= shift_q;
                     end else begin
                        err_q <= 1'b1;
                     end
`else
                     strobe_q <= 1'b1;
                     byte_q   <= shift_q;
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase

         // Watchdog overrides whatever the FSM chose on the expiry cycle.
         if (state_q != IDLE && !fall && wdog_q == WD_LAST) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            wdog_q  <= '0;
         end
      end
   end

   assign rx_byte     = byte_q;
   assign byte_strobe = strobe_q;
   assign frame_err   = err_q;

endmodule

// File: rtl/chip8_keypad.sv
// Chip-8 hex keypad from PS/2 set-2 scancodes: break/extended prefix decoding,
// held-key register and one-shot press event. Option: KEYPAD_PARITY_CHECK_EN.
module chip8_keypad
   import chip8_kbd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   input  logic        clear,
   output logic [15:0] key_state,
   output logic        key_event,
   output logic [3:0]  key_code,
   output logic        frame_err
);

   logic [7:0]  rx_byte;
   logic        rx_strobe;
   logic        rx_err;

   logic [15:0] keys_q, keys_d;
   logic        event_q, event_d;
   logic [3:0]  code_q, code_d;
   logic        brk_q, brk_d;
   logic        ext_q, ext_d;
   key_lookup_t lk;

   ps2_rx_frame #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_rx (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .ps2_clk     (ps2_clk),
      .ps2_dat     (ps2_dat),
      .rx_byte     (rx_byte),
      .byte_strobe (rx_strobe),
      .frame_err   (rx_err)
   );

   always_comb begin
      keys_d  = keys_q;
      event_d = 1'b0;
      code_d  = code_q;
      brk_d   = brk_q;
      ext_d   = ext_q;
      lk      = sc_to_key(rx_byte);

      if (clear) begin
         keys_d = '0;
         brk_d  = 1'b0;
         ext_d  = 1'b0;
      end else if (rx_strobe) begin
         if (rx_byte == SC_BREAK) begin
            brk_d = 1'b1;
         end else if (rx_byte == SC_EXT) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            // Extended keys share base codes with pad keys, so they are dropped.
            if (!ext_q && lk.valid) begin
               if (brk_q) begin
                  keys_d[lk.key] = 1'b0;
               end else if (!keys_q[lk.key]) begin
                  keys_d[lk.key] = 1'b1;
                  event_d        = 1'b1;
                  code_d         = lk.key;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         keys_q  <= '0;
         event_q <= 1'b0;
         code_q  <= '0;
         brk_q   <= 1'b0;
         ext_q   <= 1'b0;
      end else begin
         keys_q  <= keys_d;
         event_q <= event_d;
         code_q  <= code_d;
         brk_q   <= brk_d;
         ext_q   <= ext_d;
      end
   end

   assign key_state = keys_q;
   assign key_event = event_q;
   assign key_code  = code_q;
   assign frame_err = rx_err;

endmodule

// File: tb/tb_chip8_keypad.sv
// Self-checking bench for chip8_keypad: directed frames plus random scancode
// traffic against a table-driven keypad model.
module tb_chip8_keypad;

   localparam int TO = 2000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic        clear = 1'b0;
   logic [15:0] key_state;
   logic        key_event;
   logic [3:0]  key_code;
   logic        frame_err;

   int compared = 0;
   int mismatched = 0;
   int ev_cnt = 0;
   int err_cnt = 0;

   logic [15:0] m_keys = '0;
   logic        m_brk = 1'b0;
   logic        m_ext = 1'b0;
   logic [3:0]  m_code = '0;

   logic [7:0] sc_tab [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                               8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};

   chip8_keypad #(
      .TIMEOUT_CYCLES (TO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk_sys   (clk),
      .reset_n   (reset_n),
      .ps2_clk   (ps2_clk),
      .ps2_dat   (ps2_dat),
      .clear     (clear),
      .key_state (key_state),
      .key_event (key_event),
      .key_code  (key_code),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_event === 1'b1) ev_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ps2_dat = b;
      tick(10);
      ps2_clk = 1'b0;
      tick(20);
      ps2_clk = 1'b1;
      tick(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(stop);
      ps2_dat = 1'b1;
      tick(10);
   endtask

   // Keypad rules applied at the level of scancode meaning.
   task automatic model_byte(input logic [7:0] b, output int ev);
      int k;
      ev = 0;
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else begin
         k = -1;
         for (int i = 0; i < 16; i++) if (sc_tab[i] == b) k = i;
         if (!m_ext && k >= 0) begin
            if (m_brk) m_keys[k] = 1'b0;
            else if (!m_keys[k]) begin
               m_keys[k] = 1'b1;
               m_code = 4'(k);
               ev = 1;
            end
         end
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   task automatic post_check(input string tag, input int ev0, input int er0,
                             input int exp_ev, input int exp_er);
      check({tag, "_keys"}, 32'(key_state), 32'(m_keys));
      check({tag, "_events"}, 32'(ev_cnt - ev0), 32'(exp_ev));
      check({tag, "_code"}, 32'(key_code), 32'(m_code));
      check({tag, "_errs"}, 32'(err_cnt - er0), 32'(exp_er));
   endtask

   task automatic do_frame(input logic [7:0] b, input string tag);
      int ev0, er0, e;
      ev0 = ev_cnt;
      er0 = err_cnt;
      send_frame(b, 1'b0, 1'b1);
      model_byte(b, e);
      post_check(tag, ev0, er0, e, 0);
   endtask

   initial begin
      int ev0, er0, e, found, r;
      logic [7:0] b;

      tick(3);
      check("rst_keys", 32'(key_state), 32'h0);
      check("rst_event", 32'(key_event), 32'h0);
      check("rst_code", 32'(key_code), 32'h0);
      check("rst_ferr", 32'(frame_err), 32'h0);
      reset_n = 1'b1;
      tick(5);

      // Make 1D with latency check relative to the internal byte strobe
      ev0 = ev_cnt;
      er0 = err_cnt;
      fork
         send_frame(8'h1D, 1'b0, 1'b1);
         begin
            found = 0;
            for (int i = 0; i < 1000 && found == 0; i++) begin
               tick(1);
               if (dut.rx_strobe === 1'b1) found = 1;
            end
            check("strobe_seen", 32'(found), 32'd1);
            check("evt_at_strobe", 32'(key_event), 32'h0);
            tick(1);
            check("evt_lat1", 32'(key_event), 32'h1);
            check("code_lat1", 32'(key_code), 32'h5);
         end
      join
      model_byte(8'h1D, e);
      post_check("make5", ev0, er0, e, 0);
      do_frame(8'hF0, "brk5a");
      do_frame(8'h1D, "brk5b");

      for (int i = 0; i < 3; i++) do_frame(8'h22, "typematic0");

      do_frame(8'hE0, "ext_a");
      do_frame(8'h1D, "ext_b");
      do_frame(8'h2A, "keyF");

      // Partial frame then silence: watchdog abort
      ev0 = ev_cnt;
      er0 = err_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
      ps2_dat = 1'b1;
      tick(TO + 200);
      post_check("timeout", ev0, er0, 0, 1);
      do_frame(8'h16, "after_to");
      do_frame(8'hF0, "rel1a");
      do_frame(8'h16, "rel1b");

      ev0 = ev_cnt;
      er0 = err_cnt;
      send_frame(8'h16, 1'b0, 1'b0);
      post_check("badstop", ev0, er0, 0, 1);

      ev0 = ev_cnt;
      er0 = err_cnt;
      send_frame(8'h16, 1'b1, 1'b1);
`ifdef KEYPAD_PARITY_CHECK_EN
      post_check("badpar", ev0, er0, 0, 1);
`else
      model_byte(8'h16, e);
      post_check("badpar", ev0, er0, e, 0);
`endif

      do_frame(8'h16, "hold1");
      do_frame(8'h25, "holdC");

      // Clear coinciding with the strobe of make 15
      ev0 = ev_cnt;
      er0 = err_cnt;
      fork
         send_frame(8'h15, 1'b0, 1'b1);
         begin
            found = 0;
            for (int i = 0; i < 1000 && found == 0; i++) begin
               tick(1);
               if (dut.rx_strobe === 1'b1) found = 1;
            end
            clear = 1'b1;
            tick(1);
            clear = 1'b0;
         end
      join
      check("clr_strobe_seen", 32'(found), 32'd1);
      m_keys = '0;
      m_brk = 1'b0;
      m_ext = 1'b0;
      post_check("clear", ev0, er0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 5) b = sc_tab[$urandom_range(0, 15)];
         else if (r <= 7) b = 8'hF0;
         else if (r == 8) b = 8'hE0;
         else b = 8'($urandom);
         do_frame(b, "rand");
      end

      do_frame(8'h2D, "pre_rst");

      // Reset in the middle of a frame
      er0 = err_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      reset_n = 1'b0;
      tick(1);
      check("mrst_keys", 32'(key_state), 32'h0);
      check("mrst_event", 32'(key_event), 32'h0);
      check("mrst_code", 32'(key_code), 32'h0);
      check("mrst_ferr", 32'(frame_err), 32'h0);
      ps2_dat = 1'b1;
      tick(5);
      reset_n = 1'b1;
      m_keys = '0;
      m_brk = 1'b0;
      m_ext = 1'b0;
      m_code = '0;
      tick(TO + 100);
      check("mrst_noerr", 32'(err_cnt - er0), 32'd0);
      do_frame(8'h1A, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
